// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg -- shared definitions for the sequential multiply/divide unit.
//
// Contents:
//   ALUOP_MUL / ALUOP_DIV : operation codes accepted on AluOP
//   ITER_COUNT            : radix-2 iterations per operation
//   state_e               : control FSM states (IDLE, CALC, FIX, DONE)
//   is_legal_op()         : true for the two operation codes the unit executes
// -----------------------------------------------------------------------------
package muldiv_pkg;

  typedef logic [3:0] aluop_t;

  localparam aluop_t ALUOP_MUL  = 4'd3;
  localparam aluop_t ALUOP_DIV  = 4'd4;
  localparam int     ITER_COUNT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic is_legal_op(input aluop_t op);
    return (op == ALUOP_MUL) || (op == ALUOP_DIV);
  endfunction

endpackage : muldiv_pkg

// File: rtl/muldiv_if.sv
// -----------------------------------------------------------------------------
// muldiv_if -- request/response bundle of the multiply/divide unit.
//
// Signals:
//   start    : request strobe (requester -> unit)
//   AluOP    : 4'd3 multiply, 4'd4 divide (requester -> unit)
//   X, Y     : multiplicand/dividend, multiplier/divisor (requester -> unit)
//   busy     : operation in progress (unit -> requester)
//   done     : one-cycle completion pulse (unit -> requester)
//   Result   : product low word or quotient (unit -> requester)
//   Result_2 : product high word or remainder (unit -> requester)
//
// Modports: master = requester side, slave = unit side.
// -----------------------------------------------------------------------------
interface muldiv_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [3:0]       AluOP;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Result;
  logic [WIDTH-1:0] Result_2;

  modport master (
    output start, AluOP, X, Y,
    input  busy, done, Result, Result_2
  );

  modport slave (
    input  start, AluOP, X, Y,
    output busy, done, Result, Result_2
  );

endinterface : muldiv_if

// File: rtl/muldiv_iter.sv
// -----------------------------------------------------------------------------
// muldiv_iter -- one combinational radix-2 step shared by multiply and divide.
//
// The working pair {hi, lo} is a 2*WIDTH-bit shift register:
//   multiply : hi = partial product high word, lo = remaining multiplier bits
//              (product low bits shift in from the top), operand = multiplicand.
//              Add operand to hi when lo[0] is set, then shift right by one.
//   divide   : hi = partial remainder, lo = remaining dividend bits (quotient
//              bits shift in from the bottom), operand = divisor.
//              Shift left by one, subtract operand if it fits (restoring).
//
// Ports:
//   is_div   : select divide step (1) or multiply step (0)
//   hi, lo   : current working pair
//   operand  : multiplicand or divisor
//   hi_next, lo_next : working pair after this step
// -----------------------------------------------------------------------------
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next
);

  logic [WIDTH:0]   sum;      // multiply: hi + operand with carry
  logic [WIDTH:0]   shifted;  // divide: remainder shifted left with next dividend bit
  logic [WIDTH-1:0] diff;     // divide: shifted - operand, modulo 2^WIDTH
  logic             fits;     // divide: operand <= shifted

  always_comb begin
    // NOTE: every output of a combinational block gets a value before any
    // branch, so no path leaves it unassigned and no latch is inferred.
    hi_next = hi;
    lo_next = lo;

    sum     = {1'b0, hi} + {1'b0, operand};
    shifted = {hi, lo[WIDTH-1]};
    fits    = shifted >= {1'b0, operand};
    // When the subtraction is kept the true difference is below the divisor,
    // so the low WIDTH bits are exact. A zero divisor always "fits", which
    // yields an all-ones quotient and shifts the dividend into the remainder.
    diff    = shifted[WIDTH-1:0] - operand;

    if (is_div) begin
      if (fits) begin
        hi_next = diff;
        lo_next = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_next = shifted[WIDTH-1:0];
        lo_next = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (lo[0]) begin
        hi_next = sum[WIDTH:1];
        lo_next = {sum[0], lo[WIDTH-1:1]};
      end else begin
        hi_next = {1'b0, hi[WIDTH-1:1]};
        lo_next = {hi[0], lo[WIDTH-1:1]};
      end
    end
  end

endmodule : muldiv_iter

// File: rtl/muldiv_seq.sv
// -----------------------------------------------------------------------------
// muldiv_seq -- sequential 32-bit multiply / divide unit.
//
// A request (start with AluOP = multiply or divide) is accepted in IDLE or
// DONE. The unit then runs ITER_COUNT radix-2 steps in CALC, optionally a
// sign-fix cycle in FIX, and presents results in DONE with a one-cycle done.
//
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous, active-high reset; aborts any operation in flight
//   bus : muldiv_if.slave (start, AluOP, X, Y, busy, done, Result, Result_2)
//
// Build option:
//   MULDIV_SIGNED_EN : treat operands as two's complement. The core iterates
//                      on magnitudes and FIX applies the signs. Without it all
//                      operations are unsigned and FIX is never entered.
// -----------------------------------------------------------------------------
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);

  localparam int COUNT_W = $clog2(ITER_COUNT);
  localparam logic [COUNT_W-1:0] LAST_ITER = COUNT_W'(ITER_COUNT - 1);

  state_e state_q, state_d;

  logic [COUNT_W-1:0] count_q;
  logic               is_div_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic [WIDTH-1:0]   operand_q;
  logic [WIDTH-1:0]   result_q;
  logic [WIDTH-1:0]   result_2_q;

  logic [WIDTH-1:0]   hi_next;
  logic [WIDTH-1:0]   lo_next;
  logic [WIDTH-1:0]   fin_lo;
  logic [WIDTH-1:0]   fin_hi;

  logic accept;
  logic last_iter;
  logic load_result;
  logic busy;
  logic done;
  logic req_div;

  assign req_div   = (bus.AluOP == ALUOP_DIV);
  assign accept    = ((state_q == IDLE) || (state_q == DONE)) &&
                     bus.start && is_legal_op(bus.AluOP);
  assign last_iter = (state_q == CALC) && (count_q == LAST_ITER);

  // ---------------------------------------------------------------------------
  // Iteration step
  // ---------------------------------------------------------------------------
  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .is_div  (is_div_q),
    .hi      (hi_q),
    .lo      (lo_q),
    .operand (operand_q),
    .hi_next (hi_next),
    .lo_next (lo_next)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and status outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (last_iter) begin
`ifdef MULDIV_SIGNED_EN
          state_d = FIX;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef MULDIV_SIGNED_EN
      FIX: begin
        busy    = 1'b1;
        state_d = DONE;
      end
`endif
      DONE: begin
        done    = 1'b1;
        state_d = accept ? CALC : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Final result selection
  // ---------------------------------------------------------------------------
`ifdef MULDIV_SIGNED_EN
  logic neg_q;        // operand signs differ: negate product / quotient
  logic x_neg_q;      // remainder takes the sign of X
  logic div_zero_q;   // divisor was zero: quotient is forced to all ones

  logic [2*WIDTH-1:0] product;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  assign load_result = (state_q == FIX);

  always_comb begin
    product = {hi_q, lo_q};
    fin_lo  = lo_q;
    fin_hi  = hi_q;
    if (is_div_q) begin
      if (div_zero_q)  fin_lo = '1;
      else if (neg_q)  fin_lo = -lo_q;
      // A remainder magnitude of |X| re-signed gives back X for divide by zero.
      if (x_neg_q)     fin_hi = -hi_q;
    end else begin
      if (neg_q) product = -product;
      fin_hi = product[2*WIDTH-1:WIDTH];
      fin_lo = product[WIDTH-1:0];
    end
  end
`else
  // Unsigned: the last CALC step's output is the answer, captured on DONE entry.
  assign load_result = last_iter;
  assign fin_lo      = lo_next;
  assign fin_hi      = hi_next;
`endif

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: datapath registers are few and individually reset so an aborted
    // operation leaves no stale operands or results visible.
    if (rst) begin
      count_q    <= '0;
      is_div_q   <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      operand_q  <= '0;
      result_q   <= '0;
      result_2_q <= '0;
`ifdef MULDIV_SIGNED_EN
      neg_q      <= 1'b0;
      x_neg_q    <= 1'b0;
      div_zero_q <= 1'b0;
`endif
    end else begin
      if (accept) begin
        count_q   <= '0;
        is_div_q  <= req_div;
        hi_q      <= '0;
`ifdef MULDIV_SIGNED_EN
        lo_q       <= req_div ? magnitude(bus.X) : magnitude(bus.Y);
        operand_q  <= req_div ? magnitude(bus.Y) : magnitude(bus.X);
        neg_q      <= bus.X[WIDTH-1] ^ bus.Y[WIDTH-1];
        x_neg_q    <= bus.X[WIDTH-1];
        div_zero_q <= (bus.Y == '0);
`else
        lo_q      <= req_div ? bus.X : bus.Y;
        operand_q <= req_div ? bus.Y : bus.X;
`endif
      end else if (state_q == CALC) begin
        count_q <= count_q + 1'b1;
        hi_q    <= hi_next;
        lo_q    <= lo_next;
      end

      if (load_result) begin
        result_q   <= fin_lo;
        result_2_q <= fin_hi;
      end
    end
  end

  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.Result   = result_q;
  assign bus.Result_2 = result_2_q;

endmodule : muldiv_seq

// File: tb/tb_muldiv_seq.sv
// -----------------------------------------------------------------------------
// tb_muldiv_seq -- directed self-checking bench for muldiv_seq.
//
// Latency is counted in falling edges after the request is driven: the first
// falling edge after the accepting rising edge is 1, so a done visible in the
// cycle that follows the 32nd (33rd signed) post-accept rising edge reads 33
// (34). Outputs are sampled on the falling edge; inputs change there as well.
// Honours MULDIV_SIGNED_EN for expected latency and signed results.
// -----------------------------------------------------------------------------
module tb_muldiv_seq;

`ifdef MULDIV_SIGNED_EN
  localparam int LAT = 34;
`else
  localparam int LAT = 33;
`endif
  localparam int BOUND = 200;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  muldiv_if #(.WIDTH(32)) bus ();

  muldiv_seq #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Drive a request at the current falling edge.
  task automatic launch(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    bus.start = 1'b1;
    bus.AluOP = op;
    bus.X     = x;
    bus.Y     = y;
  endtask

  // Wait for done; optionally pulse an interfering request at inject_at.
  task automatic wait_done(input int inject_at, output int lat,
                           output logic [31:0] r, output logic [31:0] r2);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    r    = '0;
    r2   = '0;
    while (!seen && lat < BOUND) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        bus.start = 1'b0;
        check("busy_after_accept", {63'd0, bus.busy}, 64'd1);
      end
      if (inject_at > 0 && lat == inject_at) launch(4'd3, 32'd100, 32'd100);
      if (inject_at > 0 && lat == inject_at + 1) bus.start = 1'b0;
      if (bus.done) begin
        seen = 1'b1;
        r    = bus.Result;
        r2   = bus.Result_2;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp_r, input logic [31:0] exp_r2);
    int          lat;
    logic [31:0] r, r2;
    launch(op, x, y);
    wait_done(0, lat, r, r2);
    check({tag, "_lat"}, 64'(lat), 64'(LAT));
    check({tag, "_res"}, {32'd0, r}, {32'd0, exp_r});
    check({tag, "_res2"}, {32'd0, r2}, {32'd0, exp_r2});
    @(negedge clk);
    check({tag, "_done_pulse"}, {63'd0, bus.done}, 64'd0);
  endtask

  initial begin
    int          lat, n_busy, n_done;
    logic [31:0] r, r2;
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.AluOP = 4'd0;
    bus.X     = '0;
    bus.Y     = '0;

    // Reset state
    #1;
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check("rst_res",  {32'd0, bus.Result}, 64'd0);
    check("rst_res2", {32'd0, bus.Result_2}, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Multiply
`ifdef MULDIV_SIGNED_EN
    run_op("mul_ones", 4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
`else
    run_op("mul_ones", 4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE);
`endif
    run_op("mul_small", 4'd3, 32'd7, 32'd6, 32'd42, 32'd0);
    run_op("mul_carry", 4'd3, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0001);

    // Divide
    run_op("div_100_7", 4'd4, 32'd100, 32'd7, 32'd14, 32'd2);
`ifdef MULDIV_SIGNED_EN
    run_op("div_neg100_7", 4'd4, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
    run_op("div_ovf", 4'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000);
`else
    run_op("div_big", 4'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
`endif
    run_op("div_zero", 4'd4, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234);

    // Illegal opcode: nothing happens
    launch(4'd5, 32'd9, 32'd3);
    n_busy = 0;
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.busy) n_busy++;
      if (bus.done) n_done++;
    end
    check("illegal_busy", 64'(n_busy), 64'd0);
    check("illegal_done", 64'(n_done), 64'd0);
    check("illegal_res_held", {32'd0, bus.Result}, 64'hFFFF_FFFF);

    // Request while busy is ignored
    launch(4'd3, 32'd3, 32'd5);
    wait_done(10, lat, r, r2);
    check("busy_ign_lat", 64'(lat), 64'(LAT));
    check("busy_ign_res", {32'd0, r}, 64'd15);
    check("busy_ign_res2", {32'd0, r2}, 64'd0);
    @(negedge clk);

    // Reset abort mid-multiply
    launch(4'd3, 32'd11, 32'd13);
    repeat (15) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("abort_busy", {63'd0, bus.busy}, 64'd0);
    check("abort_res",  {32'd0, bus.Result}, 64'd0);
    check("abort_res2", {32'd0, bus.Result_2}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    check("abort_no_done", 64'(n_done), 64'd0);
    run_op("after_abort", 4'd3, 32'd11, 32'd13, 32'd143, 32'd0);

    // Back-to-back: second request driven during the DONE cycle
    launch(4'd3, 32'd9, 32'd9);
    wait_done(0, lat, r, r2);
    check("b2b_first_res", {32'd0, r}, 64'd81);
    launch(4'd4, 32'd100, 32'd7);
    wait_done(0, lat, r, r2);
    check("b2b_second_lat", 64'(lat), 64'(LAT));
    check("b2b_second_res", {32'd0, r}, 64'd14);
    check("b2b_second_res2", {32'd0, r2}, 64'd2);
    @(negedge clk);
    check("b2b_done_pulse", {63'd0, bus.done}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_muldiv_seq

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1: single clock, all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1: request strobe, sampled on clk.
REQ-005 SHALL have port AluOP, input, 4: operation code; 4'd3 = multiply, 4'd4 = divide, all other values illegal.
REQ-006 SHALL have port X, input, 32: multiplicand or dividend.
REQ-007 SHALL have port Y, input, 32: multiplier or divisor.
REQ-008 SHALL have port busy, output, 1: high while an operation is in progress.
REQ-009 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-010 SHALL have port Result, output, 32: product low word or quotient.
REQ-011 SHALL have port Result_2, output, 32: product high word or remainder.

Function
REQ-012 SHALL implement the FSM states IDLE, CALC, FIX and DONE.
REQ-013 SHALL accept a request only in IDLE or DONE, when start=1 and AluOP is 3 or 4; X, Y and AluOP are latched on that edge and the FSM enters CALC.
REQ-014 SHALL ignore start when AluOP is illegal: no state change, no busy, no done.
REQ-015 SHALL ignore start while busy=1; the latched operands are unaffected.
REQ-016 SHALL perform one radix-2 iteration per cycle in CALC for exactly 32 cycles: shift-add for multiply, restoring shift-subtract for divide.
REQ-017 SHALL pass through FIX for one cycle after CALC when signed operation is enabled (REQ-026), and go directly to DONE otherwise.
REQ-018 SHALL hold busy=1 in CALC and FIX and busy=0 in IDLE and DONE.
REQ-019 SHALL assert done for exactly one cycle in DONE, then return to IDLE unless a new request is accepted in that cycle.
REQ-020 SHALL assert done 33 cycles after the accept edge, or 34 cycles with MULDIV_SIGNED_EN.
REQ-021 SHALL update Result and Result_2 only on entry to DONE and hold them until the next DONE.
REQ-022 SHALL, for multiply, set {Result_2, Result} to the full 64-bit product.
REQ-023 SHALL, for divide by zero, set Result=32'hFFFFFFFF and Result_2=X, taking the normal latency.
REQ-024 SHALL, for signed 32'h80000000 / 32'hFFFFFFFF, set Result=32'h80000000 and Result_2=0, with no trap.

Reset
REQ-025 SHALL, while rst=1, force state=IDLE, busy=0, done=0, Result=0, Result_2=0 and all datapath registers to 0; a mid-operation reset aborts the operation with no done pulse.

Configuration
REQ-026 SHALL support macro MULDIV_SIGNED_EN.
- Defined: operands are two's complement; the core works on magnitudes; FIX negates the product if the operand signs differ, negates the quotient if the signs differ, and gives the remainder the sign of X.
- Undefined: all operations are unsigned and the FIX state is not generated.

Structure
REQ-027 SHALL place in shared package muldiv_pkg: ALUOP_MUL=4'd3, ALUOP_DIV=4'd4, the FSM state enum and ITER_COUNT=32.
REQ-028 SHALL contain one sub-module, muldiv_iter: the combinational single-iteration step (add or subtract plus shift) instantiated by the FSM datapath.

Verification
REQ-029 SHALL cover unsigned multiply: X=32'hFFFFFFFF, Y=32'hFFFFFFFF, AluOP=3 -> done at +33, Result=32'h00000001, Result_2=32'hFFFFFFFE.
REQ-030 SHALL cover divide: X=100, Y=7, AluOP=4 -> Result=14, Result_2=2; with MULDIV_SIGNED_EN and X=-100 -> Result=-14, Result_2=-2, done at +34.
REQ-031 SHALL cover divide by zero: X=32'h1234, Y=0, AluOP=4 -> Result=32'hFFFFFFFF, Result_2=32'h1234.
REQ-032 SHALL cover ignored requests: start with AluOP=5 -> busy stays 0, no done; start pulsed at +10 of an active op -> results match the first operands.
REQ-033 SHALL cover reset abort: rst asserted at +15 of a multiply -> busy=0, Result=0 asynchronously, no done; a fresh request afterwards completes normally.
REQ-034 SHALL cover back-to-back: start asserted in the DONE cycle -> accepted, and the second done follows exactly 33 (or 34) cycles later.
